// File: rtl/tl_ul_sram_responder_if.sv
// ----------------------------------------------------------------------------
// tl_ul_sram_responder_if
// TileLink-UL A/D channel bundle for a single-beat, 32-bit link.
//   master : drives the A channel and d_ready (the requesting side)
//   slave  : drives a_ready and the D channel (the responding side)
// The A channel carries opcode/param/size/source/address/mask/data/corrupt.
// The D channel carries opcode/param/size/source/sink/denied/data/corrupt.
// ----------------------------------------------------------------------------
interface tl_ul_sram_responder_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [3:0]  a_size;
  logic [5:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [3:0]  d_size;
  logic [5:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// ----------------------------------------------------------------------------
// tl_ul_sram_responder
// TileLink-UL manager that terminates Get / PutFullData / PutPartialData into
// a local synchronous SRAM of 2^DEPTH_LOG2 32-bit words and returns
// AccessAck / AccessAckData on the D channel.
//
// Ports:
//   clock : sole clock, rising edge
//   reset : synchronous, active-low
//   tl    : tl_ul_sram_responder_if.slave (A channel in, D channel out)
//
// Structure: one request stage (SRAM read data lands here one cycle after the
// accept edge) followed by a 2-entry response FIFO. The D channel shows the
// FIFO head, or the stage directly when the FIFO is empty, which gives the
// one-cycle minimum latency. a_ready is a credit check on stage + FIFO
// occupancy only, so it never depends combinationally on d_ready.
//
// Optional feature macro: TL_SRAM_RESPONDER_DENY_EN
//   defined   : out-of-window, oversized, misaligned and malformed PutFullData
//               requests are denied without touching the SRAM.
//   undefined : only unsupported opcodes are denied; the address wraps
//               modulo the window.
// ----------------------------------------------------------------------------
module tl_ul_sram_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0800_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  tl_ul_sram_responder_if.slave        tl
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [5:0]  source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } rsp_t;

`ifdef TL_SRAM_RESPONDER_DENY_EN
  // Lane set a PutFullData must carry for a given size and byte offset.
  function automatic logic [3:0] full_mask(input logic [3:0] size, input logic [1:0] offset);
    case (size)
      4'd0:    full_mask = 4'b0001 << offset;
      4'd1:    full_mask = 4'b0011 << offset;
      default: full_mask = 4'b1111;
    endcase
  endfunction
`endif

  logic [31:0]           mem_r [0:DEPTH-1];

  logic                  stage_valid_r;
  rsp_t                  stage_r;
  rsp_t                  fifo_r [0:1];
  logic                  head_r;
  logic [1:0]            count_r;

  logic                  is_get_s;
  logic                  is_put_s;
  logic                  deny_s;
  logic [DEPTH_LOG2-1:0] word_idx_s;
  logic [1:0]            occupancy_s;
  logic                  a_ready_s;
  logic                  accept_s;
  logic                  out_from_fifo_s;
  rsp_t                  head_s;
  logic                  d_valid_s;
  logic                  pop_s;
  logic                  fifo_pop_s;
  logic                  push_s;
  logic                  unused_s;

  // Request decode and deny decision for the beat currently on the A channel.
  always_comb begin
    word_idx_s = tl.a_address[DEPTH_LOG2+1:2];
    is_get_s   = (tl.a_opcode == OP_GET);
    is_put_s   = (tl.a_opcode == OP_PUT_FULL) || (tl.a_opcode == OP_PUT_PARTIAL);
`ifdef TL_SRAM_RESPONDER_DENY_EN
    deny_s = !(is_get_s || is_put_s)
          || (tl.a_address[31:DEPTH_LOG2+2] != BASE_ADDR[31:DEPTH_LOG2+2])
          || (tl.a_size > 4'd2)
          || ((tl.a_size == 4'd1) && tl.a_address[0])
          || ((tl.a_size == 4'd2) && (tl.a_address[1:0] != 2'd0))
          || ((tl.a_opcode == OP_PUT_FULL)
              && (tl.a_mask != full_mask(tl.a_size, tl.a_address[1:0])));
`else
    deny_s = !(is_get_s || is_put_s);
`endif
  end

  // Credit check, head selection and handshake bookkeeping.
  always_comb begin
    occupancy_s     = {1'b0, stage_valid_r} + count_r;
    a_ready_s       = reset && (occupancy_s < 2'd2);
    accept_s        = tl.a_valid && a_ready_s;
    out_from_fifo_s = (count_r != 2'd0);
    head_s          = out_from_fifo_s ? fifo_r[head_r] : stage_r;
    d_valid_s       = reset && (out_from_fifo_s || stage_valid_r);
    pop_s           = d_valid_s && tl.d_ready;
    fifo_pop_s      = pop_s && out_from_fifo_s;
    // The stage drains into the FIFO unless it was handed out directly.
    push_s          = stage_valid_r && !(pop_s && !out_from_fifo_s);
  end

  // SRAM byte-lane writes; contents deliberately have no reset.
  always_ff @(posedge clock) begin
    if (accept_s && is_put_s && !deny_s) begin
      for (int i = 0; i < 4; i++) begin
        if (tl.a_mask[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= tl.a_data[8*i +: 8];
        end
      end
    end
  end

  // Request stage and response FIFO.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stage_valid_r <= 1'b0;
      stage_r       <= '0;
      fifo_r[0]     <= '0;
      fifo_r[1]     <= '0;
      head_r        <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        stage_r.opcode  <= is_get_s ? OP_ACK_DATA : OP_ACK;
        stage_r.size    <= tl.a_size;
        stage_r.source  <= tl.a_source;
        stage_r.denied  <= deny_s;
        stage_r.corrupt <= is_get_s && deny_s;
        // A Put one cycle earlier has already landed, so no bypass is needed.
        stage_r.data    <= (is_get_s && !deny_s) ? mem_r[word_idx_s] : 32'h0;
      end
      if (push_s) begin
        fifo_r[head_r ^ count_r[0]] <= stage_r;
      end
      if (fifo_pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, fifo_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign tl.a_ready   = a_ready_s;
  assign tl.d_valid   = d_valid_s;
  assign tl.d_opcode  = d_valid_s ? head_s.opcode  : 3'd0;
  assign tl.d_param   = 2'd0;
  assign tl.d_size    = d_valid_s ? head_s.size    : 4'd0;
  assign tl.d_source  = d_valid_s ? head_s.source  : 6'd0;
  assign tl.d_sink    = 1'b0;
  assign tl.d_denied  = d_valid_s ? head_s.denied  : 1'b0;
  assign tl.d_data    = d_valid_s ? head_s.data    : 32'h0;
  assign tl.d_corrupt = d_valid_s ? head_s.corrupt : 1'b0;

  // a_param and a_corrupt never influence behaviour; upper address bits only
  // matter when the deny checks are built in.
  assign unused_s = ^{tl.a_param, tl.a_corrupt, tl.a_address, BASE_ADDR};

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_tl_ul_sram_responder
// Directed bench with a scoreboard: every accepted A beat pushes its
// predicted D beat (from a bench-side memory model) and every D handshake
// pops and compares it. Timing properties are checked directly.
// ----------------------------------------------------------------------------
module tb_tl_ul_sram_responder;

  localparam int          DL   = 10;
  localparam logic [31:0] BASE = 32'h0800_0000;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [3:0]  size;
    logic [5:0]  source;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_ul_sram_responder_if bus();

  tl_ul_sram_responder #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clock (clock),
    .reset (reset),
    .tl    (bus)
  );

  rsp_t        exp_q[$];
  logic [31:0] model_mem [0:(1<<DL)-1];
  int          tests = 0;
  int          fails = 0;
  int          accept_count = 0;
  int          rsp_count = 0;
  logic [31:0] last_get_data = 32'h0;
  rsp_t        last_rsp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic rsp_t predict(input logic [2:0] op, input logic [3:0] sz,
                                   input logic [5:0] src, input logic [31:0] addr,
                                   input logic [3:0] mask, input logic [31:0] data);
    rsp_t          r;
    logic          den;
    logic [DL-1:0] idx;
    r = '0;
    idx = addr[DL+1:2];
    r.size = sz;
    r.source = src;
    den = !(op == 3'd0 || op == 3'd1 || op == 3'd4);
`ifdef TL_SRAM_RESPONDER_DENY_EN
    if (addr < BASE || addr >= BASE + (32'd4 << DL)) den = 1'b1;
    if (sz > 4'd2) den = 1'b1;
    if ((sz == 4'd1 && addr[0]) || (sz == 4'd2 && addr[1:0] != 2'd0)) den = 1'b1;
    if (op == 3'd0 && sz <= 4'd2) begin
      logic [3:0] want;
      want = (sz == 4'd0) ? (4'b0001 << addr[1:0]) :
             (sz == 4'd1) ? (4'b0011 << addr[1:0]) : 4'b1111;
      if (mask != want) den = 1'b1;
    end
`endif
    r.denied = den;
    if (op == 3'd4) begin
      r.opcode = 3'd1;
      if (den) r.corrupt = 1'b1;
      else     r.data = model_mem[idx];
    end else begin
      r.opcode = 3'd0;
      if (!den && (op == 3'd0 || op == 3'd1)) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) model_mem[idx][8*i +: 8] = data[8*i +: 8];
        end
      end
    end
    return r;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clock) begin
    rsp_t e;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (bus.d_valid && bus.d_ready) begin
        rsp_count++;
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL d_unexpected: observed source %0h expected no response", bus.d_source);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("d_beat", {bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied,
                           bus.d_data, bus.d_corrupt}, e);
          check("d_param_sink", {bus.d_param, bus.d_sink}, 3'b000);
          last_rsp = {bus.d_opcode, bus.d_size, bus.d_source, bus.d_denied,
                      bus.d_data, bus.d_corrupt};
          if (bus.d_opcode == 3'd1) last_get_data = bus.d_data;
        end
      end
      if (bus.a_valid && bus.a_ready) begin
        accept_count++;
        exp_q.push_back(predict(bus.a_opcode, bus.a_size, bus.a_source,
                                bus.a_address, bus.a_mask, bus.a_data));
      end
    end
  end

  task automatic drive(input logic [2:0] op, input logic [5:0] src, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] data, input logic corrupt);
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = 3'd0;
    bus.a_size    = 4'd2;
    bus.a_source  = src;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_corrupt = corrupt;
  endtask

  // Present a beat and return at posedge+1 just after it was accepted.
  task automatic send(input logic [2:0] op, input logic [5:0] src, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic corrupt);
    int n;
    n = 0;
    drive(op, src, addr, mask, data, corrupt);
    @(negedge clock);
    while (!bus.a_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!bus.a_ready) check("a_accept_timeout", bus.a_ready, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic idle();
    bus.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("drain_timeout", exp_q.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    int rsp0;
    drive(3'd0, 6'd0, 32'h0, 4'h0, 32'h0, 1'b0);
    bus.a_valid = 1'b0;
    bus.d_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_a_ready", bus.a_ready, 1'b0);
    check("rst_d_valid", bus.d_valid, 1'b0);
    check("rst_d_payload", {bus.d_opcode, bus.d_data, bus.d_source}, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("release_a_ready", bus.a_ready, 1'b1);
    check("release_d_valid", bus.d_valid, 1'b0);
    @(posedge clock); #1;

    // PutFull then Get, with minimum latency check
    send(3'd0, 6'h05, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    idle();
    @(negedge clock);
    check("latency_d_valid", bus.d_valid, 1'b1);
    check("put_ack", {bus.d_opcode, bus.d_denied, bus.d_source}, {3'd0, 1'b0, 6'h05});
    @(posedge clock); #1;
    send(3'd4, 6'h06, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    check("get_deadbeef", last_get_data, 32'hDEAD_BEEF);
    check("get_source", last_rsp.source, 6'h06);

    // PutPartial merges a single byte lane
    send(3'd0, 6'h07, BASE + 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    send(3'd1, 6'h08, BASE + 32'h20, 4'b0010, 32'h0000_AB00, 1'b0);
    send(3'd4, 6'h09, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    check("partial_merge", last_get_data, 32'h1122_AB44);

    // Backpressure: two accepted, then a_ready low until first D handshake
    acc0 = accept_count;
    rsp0 = rsp_count;
    bus.d_ready = 1'b0;
    send(3'd4, 6'd10, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    send(3'd4, 6'd11, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    drive(3'd4, 6'd12, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_a_ready_low", bus.a_ready, 1'b0);
      check("bp_hold", {bus.d_valid, bus.d_source, bus.d_data}, {1'b1, 6'd10, 32'hDEAD_BEEF});
    end
    @(posedge clock); #1;
    check("bp_two_accepted", accept_count - acc0, 2);
    bus.d_ready = 1'b1;
    @(negedge clock);
    check("bp_release_a_ready", bus.a_ready, 1'b0);
    @(posedge clock); #1;
    @(negedge clock);
    check("bp_a_ready_rise", bus.a_ready, 1'b1);
    check("bp_dv1", bus.d_valid, 1'b1);
    @(posedge clock); #1;
    drive(3'd4, 6'd13, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    @(negedge clock);
    check("bp_dv2", bus.d_valid, 1'b1);
    @(posedge clock); #1;
    idle();
    @(negedge clock);
    check("bp_dv3", bus.d_valid, 1'b1);
    @(posedge clock); #1;
    drain();
    check("bp_accepts", accept_count - acc0, 4);
    check("bp_responses", rsp_count - rsp0, 4);

    // 16 back-to-back requests, Put/Get pairs on fresh words
    rsp0 = rsp_count;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        drive(3'd0, 6'(i), BASE + 32'h100 + 32'(4 * (i / 2)), 4'hF, 32'hA500_0000 | 32'(i), 1'b0);
      else
        drive(3'd4, 6'(i), BASE + 32'h100 + 32'(4 * (i / 2)), 4'hF, 32'h0, 1'b0);
      @(negedge clock);
      check("burst_a_ready", bus.a_ready, 1'b1);
      if (i > 0) check("burst_d_valid", bus.d_valid, 1'b1);
      @(posedge clock); #1;
    end
    idle();
    @(negedge clock);
    check("burst_last_d_valid", bus.d_valid, 1'b1);
    @(negedge clock);
    check("burst_end_d_valid", bus.d_valid, 1'b0);
    @(posedge clock); #1;
    check("burst_responses", rsp_count - rsp0, 16);

    // Unsupported opcode denied, memory untouched; corrupt Put still writes
    send(3'd3, 6'h20, BASE + 32'h10, 4'hF, 32'h1234_5678, 1'b0);
    idle();
    drain();
    check("logical_denied", {last_rsp.opcode, last_rsp.denied}, {3'd0, 1'b1});
    send(3'd4, 6'h21, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    send(3'd0, 6'h22, BASE + 32'h30, 4'hF, 32'hCAFE_F00D, 1'b1);
    send(3'd4, 6'h23, BASE + 32'h30, 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    check("corrupt_put_written", last_get_data, 32'hCAFE_F00D);

`ifdef TL_SRAM_RESPONDER_DENY_EN
    send(3'd4, 6'h24, BASE - 32'h4, 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    check("oob_get_denied", {last_rsp.denied, last_rsp.corrupt, last_rsp.data},
          {1'b1, 1'b1, 32'h0});
`endif

    // Reset with two responses pending drops them
    bus.d_ready = 1'b0;
    send(3'd4, 6'h30, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    send(3'd4, 6'h31, BASE + 32'h20, 4'hF, 32'h0, 1'b0);
    idle();
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_d_valid", bus.d_valid, 1'b0);
    check("mid_rst_a_ready", bus.a_ready, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    bus.d_ready = 1'b1;
    @(negedge clock);
    check("post_rst_a_ready", bus.a_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_stale", bus.d_valid, 1'b0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    send(3'd4, 6'h32, BASE + 32'h10, 4'hF, 32'h0, 1'b0);
    idle();
    drain();
    check("post_rst_mem_kept", last_get_data, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
